// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//    Second stage of the micro pipeline, between fetch and execute.
//    Registers the fetched 16-bit instruction, decodes its fields and reads
//    two operands from the 8 x DW register file owned by this stage. Handles
//    write-back (with same-cycle read bypass), load-use hazard detection
//    (stalling fetch for one cycle) and squashing on branch flush.
//
// Ports
//    Clk, Rst          clock, synchronous active-high reset
//    if_instr/pc/valid fetched instruction, its PC, and its validity
//    flush             taken branch/jump in execute: squash this decode
//    ex_valid/is_load/rd  instruction currently in execute (hazard check)
//    wb_we/addr/data   register file write-back port
//    stall_if          combinational: fetch holds PC and instruction
//    id_*              registered decode outputs toward execute
//
// Instruction layout
//    [15:12] opcode  [11:9] rd  [8:6] rs1  [5:3] rs2  [2:0] aux
//    LOADI immediate lives in [7:0].
//
// State | meaning (implicit in id_valid)
//    RUN    | id_valid = 1, id_* carry a real instruction
//    BUBBLE | id_valid = 0, inserted on flush, load-use hazard or invalid fetch
// ---------------------------------------------------------------------------
module decode_stage #(
   parameter int DW  = 8,
   parameter int AW  = 3,
   parameter int PCW = 8
) (
   input  logic           Clk,
   input  logic           Rst,
   input  logic [15:0]    if_instr,
   input  logic [PCW-1:0] if_pc,
   input  logic           if_valid,
   input  logic           flush,
   input  logic           ex_valid,
   input  logic           ex_is_load,
   input  logic [AW-1:0]  ex_rd,
   input  logic           wb_we,
   input  logic [AW-1:0]  wb_addr,
   input  logic [DW-1:0]  wb_data,
   output logic           stall_if,
   output logic           id_valid,
   output logic [3:0]     id_op,
   output logic [AW-1:0]  id_rd,
   output logic [DW-1:0]  id_a,
   output logic [DW-1:0]  id_b,
   output logic [7:0]     id_imm,
   output logic [2:0]     id_aux,
   output logic [PCW-1:0] id_pc
);

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_AND   = 4'h3;
   localparam logic [3:0] OP_OR    = 4'h4;
   localparam logic [3:0] OP_NOT   = 4'h5;
   localparam logic [3:0] OP_LOADI = 4'h6;
   localparam logic [3:0] OP_LOAD  = 4'h7;
   localparam logic [3:0] OP_STORE = 4'h8;
   localparam logic [3:0] OP_BRZ   = 4'h9;
   localparam logic [3:0] OP_BRNZ  = 4'hA;
   localparam logic [3:0] OP_JMP   = 4'hB;
   localparam logic [3:0] OP_INOUT = 4'hC;

   localparam int NREG = 1 << AW;

   // ------------------------------------------------------------------
   // Field extraction
   // ------------------------------------------------------------------
   logic [3:0]    f_op;
   logic [AW-1:0] f_rd;
   logic [AW-1:0] f_rs1;
   logic [AW-1:0] f_rs2;
   logic [2:0]    f_aux;
   logic [7:0]    f_imm;

   assign f_op  = if_instr[15:12];
   assign f_rd  = if_instr[11:9];
   assign f_rs1 = if_instr[8:6];
   assign f_rs2 = if_instr[5:3];
   assign f_aux = if_instr[2:0];
   assign f_imm = if_instr[7:0];

   // ------------------------------------------------------------------
   // Source usage; unknown opcodes collapse to NOP but keep id_valid
   // ------------------------------------------------------------------
   logic       rs1_used;
   logic       rs2_used;
   logic [3:0] op_dec;

   always_comb begin
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      op_dec   = f_op;
      case (f_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OP_NOT, OP_JMP, OP_INOUT: begin
            rs1_used = 1'b1;
         end
         OP_STORE, OP_BRZ, OP_BRNZ: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OP_LOAD: begin
            rs2_used = 1'b1;
         end
         OP_LOADI, OP_NOP: begin
            rs1_used = 1'b0;
         end
         default: begin
            op_dec = OP_NOP;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Register file with write-back bypass on read
   // ------------------------------------------------------------------
   logic [DW-1:0] rf_q [NREG];
   logic [DW-1:0] rf_d [NREG];
   logic [DW-1:0] rd_a;
   logic [DW-1:0] rd_b;

   always_comb begin
      rf_d = rf_q;
      if (wb_we) begin
         rf_d[wb_addr] = wb_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         rf_q <= rf_d;
      end
   end

   always_comb begin
      rd_a = rf_q[f_rs1];
      rd_b = rf_q[f_rs2];
      if (wb_we && (wb_addr == f_rs1)) begin
         rd_a = wb_data;
      end
      if (wb_we && (wb_addr == f_rs2)) begin
         rd_b = wb_data;
      end
   end

   // ------------------------------------------------------------------
   // Load-use hazard. A LOAD leaves execute on the next edge, so the
   // stall is inherently one cycle; no counter is needed. Flush wins,
   // and reset suppresses the stall so fetch is never held in reset.
   // ------------------------------------------------------------------
   logic hz;

   assign hz = if_valid & ex_valid & ex_is_load &
               ((rs1_used & (f_rs1 == ex_rd)) | (rs2_used & (f_rs2 == ex_rd)));

   assign stall_if = hz & ~flush & ~Rst;

   // ------------------------------------------------------------------
   // Pipeline register
   // ------------------------------------------------------------------
   logic           valid_q, valid_d;
   logic [3:0]     op_q,    op_d;
   logic [AW-1:0]  rd_q,    rd_d;
   logic [DW-1:0]  a_q,     a_d;
   logic [DW-1:0]  b_q,     b_d;
   logic [7:0]     imm_q,   imm_d;
   logic [2:0]     aux_q,   aux_d;
   logic [PCW-1:0] pc_q,    pc_d;

   always_comb begin
      valid_d = valid_q;
      op_d    = op_q;
      rd_d    = rd_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      aux_d   = aux_q;
      pc_d    = pc_q;
      if (flush) begin
         // Squash only; payload is don't-care so it is simply held.
         valid_d = 1'b0;
      end else if (hz) begin
         valid_d = 1'b0;
         op_d    = OP_NOP;
      end else begin
         valid_d = if_valid;
         op_d    = op_dec;
         rd_d    = f_rd;
         a_d     = rd_a;
         b_d     = rd_b;
         imm_d   = f_imm;
         aux_d   = f_aux;
         pc_d    = if_pc;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         valid_q <= 1'b0;
         op_q    <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         aux_q   <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         aux_q   <= aux_d;
         pc_q    <= pc_d;
      end
   end

   assign id_valid = valid_q;
   assign id_op    = op_q;
   assign id_rd    = rd_q;
   assign id_a     = a_q;
   assign id_b     = b_q;
   assign id_imm   = imm_q;
   assign id_aux   = aux_q;
   assign id_pc    = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

   localparam logic [3:0] NOP   = 4'h0;
   localparam logic [3:0] ADD   = 4'h1;
   localparam logic [3:0] SUB   = 4'h2;
   localparam logic [3:0] NOT_  = 4'h5;
   localparam logic [3:0] LOADI = 4'h6;
   localparam logic [3:0] LOAD  = 4'h7;
   localparam logic [3:0] STORE = 4'h8;
   localparam logic [3:0] BRZ   = 4'h9;
   localparam logic [3:0] JMP   = 4'hB;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [15:0] if_instr;
   logic [7:0]  if_pc;
   logic        if_valid;
   logic        flush;
   logic        ex_valid;
   logic        ex_is_load;
   logic [2:0]  ex_rd;
   logic        wb_we;
   logic [2:0]  wb_addr;
   logic [7:0]  wb_data;
   logic        stall_if;
   logic        id_valid;
   logic [3:0]  id_op;
   logic [2:0]  id_rd;
   logic [7:0]  id_a;
   logic [7:0]  id_b;
   logic [7:0]  id_imm;
   logic [2:0]  id_aux;
   logic [7:0]  id_pc;

   decode_stage #(.DW(8), .AW(3), .PCW(8)) dut (
      .Clk(Clk), .Rst(Rst),
      .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
      .flush(flush),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .stall_if(stall_if),
      .id_valid(id_valid), .id_op(id_op), .id_rd(id_rd),
      .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_aux(id_aux),
      .id_pc(id_pc)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       valid;
      logic [3:0] op;
      logic [2:0] rd;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] imm;
      logic [2:0] aux;
      logic [7:0] pc;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       m_out;
   logic [7:0] rf_m [8];
   int         n_asrt = 0;
   int         n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [2:0] aux);
      return {op, rd, rs1, rs2, aux};
   endfunction

   // One directed cycle: drive, check combinational stall, push expected,
   // clock, pop and compare registered outputs.
   task automatic step(input string tag, input logic rst, input logic [15:0] instr,
                       input logic [7:0] pc, input logic iv, input logic fl,
                       input logic exv, input logic exl, input logic [2:0] exrd,
                       input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic exp_stall);
      exp_t       e;
      logic [3:0] opm;
      logic [2:0] rs1, rs2;
      Rst = rst; if_instr = instr; if_pc = pc; if_valid = iv; flush = fl;
      ex_valid = exv; ex_is_load = exl; ex_rd = exrd;
      wb_we = we; wb_addr = wa; wb_data = wd;
      #1;
      chk({tag, ".stall"}, {31'd0, stall_if}, {31'd0, exp_stall});
      rs1 = instr[8:6];
      rs2 = instr[5:3];
      opm = instr[15:12];
      if (opm > 4'hC) opm = NOP;
      if (rst) begin
         m_out = '0;
      end else if (fl) begin
         m_out.valid = 1'b0;
      end else if (exp_stall) begin
         m_out.valid = 1'b0;
         m_out.op    = NOP;
      end else begin
         m_out.valid = iv;
         m_out.op    = opm;
         m_out.rd    = instr[11:9];
         m_out.a     = (we && wa == rs1) ? wd : rf_m[rs1];
         m_out.b     = (we && wa == rs2) ? wd : rf_m[rs2];
         m_out.imm   = instr[7:0];
         m_out.aux   = instr[2:0];
         m_out.pc    = pc;
      end
      if (rst) begin
         for (int i = 0; i < 8; i++) rf_m[i] = 8'h00;
      end else if (we) begin
         rf_m[wa] = wd;
      end
      sb_q.push_back(m_out);
      @(posedge Clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, e.valid});
         chk({tag, ".op"},    {28'd0, id_op},    {28'd0, e.op});
         chk({tag, ".rd"},    {29'd0, id_rd},    {29'd0, e.rd});
         chk({tag, ".a"},     {24'd0, id_a},     {24'd0, e.a});
         chk({tag, ".b"},     {24'd0, id_b},     {24'd0, e.b});
         chk({tag, ".imm"},   {24'd0, id_imm},   {24'd0, e.imm});
         chk({tag, ".aux"},   {29'd0, id_aux},   {29'd0, e.aux});
         chk({tag, ".pc"},    {24'd0, id_pc},    {24'd0, e.pc});
      end
   endtask

   initial begin
      m_out = '0;
      for (int i = 0; i < 8; i++) rf_m[i] = 8'hxx;
      @(negedge Clk);

      // Reset for two edges, with a hazard pattern and a write presented.
      step("rst0", 1, mk(ADD, 3'd1, 3'd2, 3'd5, 3'd0), 8'h10, 1, 0, 1, 1, 3'd5, 1, 3'd2, 8'hFF, 0);
      step("rst1", 1, mk(ADD, 3'd1, 3'd2, 3'd5, 3'd0), 8'h10, 1, 0, 1, 1, 3'd5, 0, 3'd0, 8'h00, 0);

      // All registers read zero after reset.
      for (int i = 0; i < 8; i++) begin
         step("rd_zero", 0, mk(ADD, i[2:0], i[2:0], 3'(7 - i), 3'(i)), 8'(8'h20 + i),
              1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 0);
      end

      // Write R3 then read it through both ports.
      step("wr_r3", 0, mk(NOP, 3'd0, 3'd0, 3'd0, 3'd0), 8'h30, 1, 0, 0, 0, 3'd0, 1, 3'd3, 8'h5A, 0);
      step("add33", 0, mk(ADD, 3'd1, 3'd3, 3'd3, 3'd4), 8'h31, 1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 0);

      // Same-cycle write-back bypass.
      step("bypass", 0, mk(SUB, 3'd0, 3'd2, 3'd3, 3'd1), 8'h32, 1, 0, 0, 0, 3'd0, 1, 3'd2, 8'hC3, 0);
      step("after_bp", 0, mk(ADD, 3'd7, 3'd2, 3'd2, 3'd0), 8'h33, 1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 0);

      // Load-use on rs2, then the ADD issues once the LOAD has moved on.
      step("lu_rs2", 0, mk(ADD, 3'd6, 3'd1, 3'd5, 3'd0), 8'h40, 1, 0, 1, 1, 3'd5, 0, 3'd0, 8'h00, 1);
      step("lu_go",  0, mk(ADD, 3'd6, 3'd1, 3'd5, 3'd0), 8'h40, 1, 0, 1, 0, 3'd5, 0, 3'd0, 8'h00, 0);

      // Load-use on rs1 via NOT and JMP; STORE/BRZ via rs2; LOAD via rs2.
      step("lu_not", 0, mk(NOT_, 3'd2, 3'd4, 3'd0, 3'd0), 8'h41, 1, 0, 1, 1, 3'd4, 0, 3'd0, 8'h00, 1);
      step("lu_jmp", 0, mk(JMP, 3'd0, 3'd6, 3'd1, 3'd0), 8'h42, 1, 0, 1, 1, 3'd6, 0, 3'd0, 8'h00, 1);
      step("lu_st",  0, mk(STORE, 3'd0, 3'd1, 3'd7, 3'd0), 8'h43, 1, 0, 1, 1, 3'd7, 0, 3'd0, 8'h00, 1);
      step("lu_brz", 0, mk(BRZ, 3'd0, 3'd2, 3'd3, 3'd0), 8'h44, 1, 0, 1, 1, 3'd3, 0, 3'd0, 8'h00, 1);
      step("lu_ld",  0, mk(LOAD, 3'd1, 3'd0, 3'd2, 3'd0), 8'h45, 1, 0, 1, 1, 3'd2, 0, 3'd0, 8'h00, 1);

      // Unused source fields never stall.
      step("ns_not", 0, mk(NOT_, 3'd2, 3'd4, 3'd5, 3'd0), 8'h50, 1, 0, 1, 1, 3'd5, 0, 3'd0, 8'h00, 0);
      step("ns_ld",  0, mk(LOAD, 3'd1, 3'd3, 3'd2, 3'd0), 8'h51, 1, 0, 1, 1, 3'd3, 0, 3'd0, 8'h00, 0);
      step("ns_li",  0, {LOADI, 3'd4, 1'b0, 8'h09}, 8'h52, 1, 0, 1, 1, 3'd4, 0, 3'd0, 8'h00, 0);
      step("ns_li2", 0, {LOADI, 3'd4, 1'b0, 8'hC8}, 8'h53, 1, 0, 1, 1, 3'd3, 0, 3'd0, 8'h00, 0);
      step("ns_exv", 0, mk(ADD, 3'd1, 3'd5, 3'd5, 3'd0), 8'h54, 1, 0, 0, 1, 3'd5, 0, 3'd0, 8'h00, 0);
      step("ns_nld", 0, mk(ADD, 3'd1, 3'd5, 3'd5, 3'd0), 8'h55, 1, 0, 1, 0, 3'd5, 0, 3'd0, 8'h00, 0);
      step("ns_iv0", 0, mk(ADD, 3'd1, 3'd5, 3'd5, 3'd0), 8'h56, 0, 0, 1, 1, 3'd5, 0, 3'd0, 8'h00, 0);

      // Flush together with a hazard, then a plain flush.
      step("reload", 0, mk(ADD, 3'd5, 3'd3, 3'd2, 3'd6), 8'h60, 1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 0);
      step("fl_hz",  0, mk(ADD, 3'd1, 3'd5, 3'd0, 3'd0), 8'h61, 1, 1, 1, 1, 3'd5, 0, 3'd0, 8'h00, 0);
      step("fl",     0, mk(SUB, 3'd2, 3'd1, 3'd1, 3'd0), 8'h62, 1, 1, 0, 0, 3'd0, 0, 3'd0, 8'h00, 0);

      // Unknown opcode decodes as NOP but stays valid.
      step("unk_op", 0, {4'hE, 3'd3, 3'd3, 3'd2, 3'd5}, 8'h70, 1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 0);

      // R0 is writable.
      step("wr_r0", 0, mk(NOP, 3'd0, 3'd0, 3'd0, 3'd0), 8'h71, 1, 0, 0, 0, 3'd0, 1, 3'd0, 8'h11, 0);
      step("rd_r0", 0, mk(ADD, 3'd0, 3'd0, 3'd3, 3'd0), 8'h72, 1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 0);

      // Reset in the middle of a stall clears everything.
      step("mid_hz", 0, mk(ADD, 3'd1, 3'd0, 3'd3, 3'd0), 8'h80, 1, 0, 1, 1, 3'd3, 0, 3'd0, 8'h00, 1);
      step("mid_rst", 1, mk(ADD, 3'd1, 3'd0, 3'd3, 3'd0), 8'h80, 1, 0, 1, 1, 3'd3, 0, 3'd0, 8'h00, 0);
      step("post_rst", 0, mk(ADD, 3'd1, 3'd0, 3'd3, 3'd2), 8'h81, 1, 0, 0, 0, 3'd0, 0, 3'd0, 8'h00, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
